// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one load/store per accepted instruction on the data-SRAM bus.
// Hands WB the raw read word; misaligned accesses are flagged here and never reach the bus.
module mem_access_stage #(
    parameter int unsigned CTRL_W   = 8,
    parameter logic [2:0]  EXC_ADEL = 3'd4,
    parameter logic [2:0]  EXC_ADES = 3'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       aluout_in,
    input  logic [31:0]       store_data,
    input  logic [2:0]        mem_type,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        exception_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    output logic              stall_out,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              out_valid,
    output logic [31:0]       aluout,
    output logic [31:0]       Memdata,
    output logic [2:0]        MemReadTypeW,
    output logic              MemWriteW,
    output logic [2:0]        exception_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      r_state, w_state_next;
    logic        r_drop, w_drop_next;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_size;
    logic        r_wr, r_rd;

    logic        w_accept, w_is_mem, w_misaligned, w_mis_exc, w_bypass, w_start, w_done;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    assign in_ready     = (r_state == StIdle) && !flush;
    assign stall_out    = (r_state != StIdle);
    assign w_accept     = in_valid && in_ready;
    assign w_is_mem     = mem_read || mem_write;
    assign w_misaligned = ((mem_type[1:0] == 2'b01) && aluout_in[0]) ||
                          ((mem_type[1:0] == 2'b10) && (aluout_in[1:0] != 2'b00));
    assign w_mis_exc    = w_is_mem && w_misaligned;
    // Anything that cannot legally touch the bus completes in one cycle from IDLE.
    assign w_bypass     = !w_is_mem || (exception_in != 3'd0) || w_misaligned;
    assign w_start      = w_accept && !w_bypass;
    assign w_done       = (r_state == StData) && data_data_ok;

    assign data_req   = (r_state == StAddr);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
        case (mem_type[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << aluout_in[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = aluout_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StAddr;
                    w_drop_next  = 1'b0;
                end
            end
            StAddr: begin
                // Once the address is taken the transaction must drain even if killed.
                if (data_addr_ok) begin
                    w_state_next = StData;
                    w_drop_next  = flush;
                end else if (flush) begin
                    w_state_next = StIdle;
                end
            end
            StData: begin
                if (flush) w_drop_next = 1'b1;
                if (data_data_ok) begin
                    w_state_next = StIdle;
                    w_drop_next  = 1'b0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_size  <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else if (w_start) begin
            r_addr  <= {aluout_in[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= mem_write ? w_wstrb : 4'b0000;
            r_size  <= mem_type[1:0];
            r_wr    <= mem_write;
            r_rd    <= mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            aluout        <= '0;
            Memdata       <= '0;
            MemReadTypeW  <= '0;
            MemWriteW     <= 1'b0;
            exception_out <= '0;
            ctrl_out      <= '0;
        end else begin
            out_valid <= 1'b0;
            if (w_accept) begin
                aluout       <= aluout_in;
                Memdata      <= '0;
                MemReadTypeW <= mem_type;
                MemWriteW    <= 1'b0;
                ctrl_out     <= ctrl_in;
                if (w_bypass) begin
                    out_valid <= 1'b1;
                    if (exception_in != 3'd0) begin
                        exception_out <= exception_in;
                    end else if (w_mis_exc) begin
                        exception_out <= mem_read ? EXC_ADEL : EXC_ADES;
                    end else begin
                        exception_out <= 3'd0;
                    end
                end else begin
                    exception_out <= 3'd0;
                end
            end else if (w_done && !r_drop && !flush) begin
                out_valid <= 1'b1;
                Memdata   <= r_rd ? data_rdata : 32'd0;
                MemWriteW <= r_wr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a behavioural bus slave.
module tb_mem_access_stage;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [31:0]   aluout_in = '0, store_data = '0;
    logic [2:0]    mem_type = '0;
    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]    exception_in = '0;
    logic [CW-1:0] ctrl_in = '0;
    logic          flush = 1'b0;
    logic          stall_out, data_req, data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr, data_wdata;
    logic [3:0]    data_wstrb;
    logic          data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0]   data_rdata = '0;
    logic          out_valid;
    logic [31:0]   aluout, Memdata;
    logic [2:0]    MemReadTypeW, exception_out;
    logic          MemWriteW;
    logic [CW-1:0] ctrl_out;

    mem_access_stage #(.CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluout_in(aluout_in), .store_data(store_data), .mem_type(mem_type),
        .mem_read(mem_read), .mem_write(mem_write), .exception_in(exception_in),
        .ctrl_in(ctrl_in), .flush(flush), .stall_out(stall_out), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .out_valid(out_valid),
        .aluout(aluout), .Memdata(Memdata), .MemReadTypeW(MemReadTypeW),
        .MemWriteW(MemWriteW), .exception_out(exception_out), .ctrl_out(ctrl_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]   aluout, memdata;
        logic [2:0]    rtype, exc;
        logic          mw;
        logic [CW-1:0] ctrl;
        int unsigned   cyc;
    } out_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
        logic        wr;
        logic [1:0]  size;
        int unsigned adly, ddly;
    } bus_t;

    out_t out_q[$];
    bus_t bus_q[$];
    bit   s_block = 1'b0;
    int unsigned last_ov = 0;

    function automatic void chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endfunction

    // Reference behaviour derived from byte-level address arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] mt, input logic rd, input logic wr,
                                  input logic [2:0] exc, input logic [CW-1:0] ctrl,
                                  input logic [31:0] rdata,
                                  output bit bus, output out_t o, output bus_t b);
        int unsigned nb, m;
        bit mem, mis;
        nb  = 1 << mt[1:0];
        mem = rd || wr;
        mis = mem && ((a % nb) != 0);
        bus = mem && (exc == 3'd0) && !mis;
        o.aluout  = a;
        o.rtype   = mt;
        o.ctrl    = ctrl;
        o.memdata = '0;
        o.mw      = 1'b0;
        o.exc     = exc;
        o.cyc     = 0;
        if (exc == 3'd0 && mis) o.exc = rd ? 3'd4 : 3'd5;
        if (bus) begin
            o.memdata = rd ? rdata : 32'd0;
            o.mw      = wr;
        end
        b.addr  = a & ~32'h3;
        b.wr    = wr;
        b.size  = mt[1:0];
        b.rdata = rdata;
        m = ((1 << nb) - 1) << (a % 4);
        b.wstrb = wr ? m[3:0] : 4'b0000;
        for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
        b.adly = 0;
        b.ddly = 0;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mt,
                         input logic rd, input logic wr, input logic [2:0] exc,
                         input int unsigned adly, input int unsigned ddly,
                         input logic [31:0] rdata, input bit kill, output int waited);
        out_t o;
        bus_t b;
        bit bus;
        logic [CW-1:0] ctrl;
        ctrl = CW'($urandom);
        model(a, d, mt, rd, wr, exc, ctrl, rdata, bus, o, b);
        b.adly = adly;
        b.ddly = ddly;
        in_valid = 1'b1; aluout_in = a; store_data = d; mem_type = mt;
        mem_read = rd; mem_write = wr; exception_in = exc; ctrl_in = ctrl;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                chk(1'b0, "accept_timeout", $sformatf("addr %h never accepted", a));
                break;
            end
            @(posedge clk); #1;
        end
        o.cyc = cyc + (bus ? 3 + adly + ddly : 1);
        if (bus) bus_q.push_back(b);
        if (!kill) out_q.push_back(o);
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; exception_in = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((out_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(n < 100, "drain", $sformatf("pending out=%0d bus=%0d after %0d cycles",
                                        out_q.size(), bus_q.size(), n));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation, in the exact cycle.
    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                last_ov = cyc;
                if (out_q.size() == 0) begin
                    chk(1'b0, "unexpected_out_valid", $sformatf("cyc %0d aluout %h", cyc, aluout));
                end else begin
                    e = out_q.pop_front();
                    chk(aluout == e.aluout && Memdata == e.memdata && MemReadTypeW == e.rtype &&
                        MemWriteW == e.mw && exception_out == e.exc && ctrl_out == e.ctrl &&
                        cyc == e.cyc, "wb_bundle",
                        $sformatf("got alu=%h mem=%h rt=%h mw=%b exc=%h ctrl=%h cyc=%0d exp alu=%h mem=%h rt=%h mw=%b exc=%h ctrl=%h cyc=%0d",
                                  aluout, Memdata, MemReadTypeW, MemWriteW, exception_out,
                                  ctrl_out, cyc, e.aluout, e.memdata, e.rtype, e.mw, e.exc,
                                  e.ctrl, e.cyc));
                end
            end
        end
    end

    // Bus slave: acks the address after adly cycles, data after a further ddly cycles.
    initial begin : slave
        int unsigned phase = 0, cnt = 0;
        bus_t b;
        forever begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (rst) begin
                phase = 0;
                cnt   = 0;
            end else if (phase == 0) begin
                if (data_req) begin
                    if (bus_q.size() == 0) begin
                        chk(1'b0, "unexpected_req", $sformatf("addr %h wr %b", data_addr, data_wr));
                    end else begin
                        b = bus_q[0];
                        chk(data_addr == b.addr && data_wr == b.wr && data_size == b.size &&
                            data_wstrb == b.wstrb && data_wdata == b.wdata && stall_out,
                            "bus_req",
                            $sformatf("got a=%h wr=%b sz=%h st=%h wd=%h stall=%b exp a=%h wr=%b sz=%h st=%h wd=%h",
                                      data_addr, data_wr, data_size, data_wstrb, data_wdata,
                                      stall_out, b.addr, b.wr, b.size, b.wstrb, b.wdata));
                        if (!s_block) begin
                            if (cnt >= b.adly) begin
                                data_addr_ok = 1'b1;
                                phase = 1;
                                cnt   = 0;
                            end else begin
                                cnt++;
                            end
                        end
                    end
                end else begin
                    cnt = 0;
                    // Stray data_ok while idle must be ignored.
                    data_data_ok = ($urandom_range(0, 3) == 0);
                end
            end else if (bus_q.size() == 0) begin
                phase = 0;
            end else begin
                b = bus_q[0];
                chk(!data_req && stall_out, "data_wait",
                    $sformatf("got req=%b stall=%b exp req=0 stall=1", data_req, stall_out));
                if (cnt >= b.ddly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = b.rdata;
                    phase = 0;
                    cnt   = 0;
                    void'(bus_q.pop_front());
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int w;
        int unsigned s, kind, adly, ddly;
        logic [31:0] a;
        logic [2:0] mt, exc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!out_valid && aluout == 0 && Memdata == 0 && MemReadTypeW == 0 && !MemWriteW &&
            exception_out == 0 && ctrl_out == 0 && !data_req && !stall_out && in_ready,
            "reset_state",
            $sformatf("got ov=%b alu=%h mem=%h rt=%h mw=%b exc=%h ctrl=%h req=%b stall=%b rdy=%b",
                      out_valid, aluout, Memdata, MemReadTypeW, MemWriteW, exception_out,
                      ctrl_out, data_req, stall_out, in_ready));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: ALU op, lw with late addr_ok, sb/sh lane placement, misaligned lh/sw.
        issue(32'h0000_1234, 32'h0, 3'b010, 1'b0, 1'b0, 3'd0, 0, 0, 32'h0, 1'b0, w);
        issue(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 3'd0, 2, 0, 32'hDEAD_BEEF, 1'b0, w);
        issue(32'h1000_0003, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 3'd0, 1, 1, 32'h0, 1'b0, w);
        issue(32'h1000_0002, 32'h1234_5678, 3'b001, 1'b0, 1'b1, 3'd0, 0, 2, 32'h0, 1'b0, w);
        issue(32'h2000_0001, 32'h0, 3'b101, 1'b1, 1'b0, 3'd0, 0, 0, 32'h0, 1'b0, w);
        issue(32'h2000_0002, 32'h5555_AAAA, 3'b010, 1'b0, 1'b1, 3'd0, 0, 0, 32'h0, 1'b0, w);
        issue(32'h2000_0000, 32'h0, 3'b010, 1'b1, 1'b0, 3'd3, 0, 0, 32'h0, 1'b0, w);
        drain();

        // Flush in IDLE: nothing accepted.
        flush = 1'b1; in_valid = 1'b1; aluout_in = 32'h77; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk(!in_ready, "flush_idle_ready", $sformatf("got in_ready=%b exp 0", in_ready));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Flush in ADDR before addr_ok: request withdrawn, no completion.
        s_block = 1'b1;
        issue(32'h0000_0100, 32'h0, 3'b010, 1'b1, 1'b0, 3'd0, 0, 0, 32'h0, 1'b1, w);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk(!data_req && !stall_out, "flush_addr_drop",
            $sformatf("got req=%b stall=%b exp 0 0", data_req, stall_out));
        void'(bus_q.pop_front());
        s_block = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Flush in DATA: transaction drains silently, next instruction taken right after.
        issue(32'h0000_0200, 32'h0, 3'b010, 1'b1, 1'b0, 3'd0, 0, 3, 32'h1111_2222, 1'b1, w);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        w = 0;
        while (!data_data_ok && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(w < 20, "flush_data_drain", $sformatf("data_ok not seen after %0d cycles", w));
        @(posedge clk); #1;
        issue(32'h0000_4321, 32'h0, 3'b010, 1'b0, 1'b0, 3'd0, 0, 0, 32'h0, 1'b0, w);
        chk(w == 0, "flush_data_next_accept", $sformatf("got wait=%0d exp 0", w));
        drain();

        // Back-to-back loads/stores at earliest acks: one completion every 3 cycles.
        s = cyc;
        for (int i = 0; i < 6; i++) begin
            issue(32'h4000_0000 + 32'(i * 4), $urandom, 3'b010, (i % 2) == 0, (i % 2) == 1,
                  3'd0, 0, 0, $urandom, 1'b0, w);
        end
        drain();
        chk(last_ov - s == 18, "b2b_throughput",
            $sformatf("got span=%0d cycles exp 18", last_ov - s));

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            mt   = {1'($urandom), 2'($urandom_range(0, 2))};
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << mt[1:0]) - 1);
            exc  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            adly = $urandom_range(0, 3);
            ddly = $urandom_range(0, 3);
            issue(a, $urandom, mt, kind == 1, kind == 2, exc, adly, ddly, $urandom, 1'b0, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Reset while waiting for data.
        issue(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 3'd0, 0, 6, 32'h0, 1'b1, w);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk(!out_valid && aluout == 0 && Memdata == 0 && MemReadTypeW == 0 && !MemWriteW &&
            exception_out == 0 && ctrl_out == 0 && !data_req && !stall_out,
            "reset_in_data",
            $sformatf("got ov=%b alu=%h mem=%h rt=%h mw=%b exc=%h ctrl=%h req=%b stall=%b",
                      out_valid, aluout, Memdata, MemReadTypeW, MemWriteW, exception_out,
                      ctrl_out, data_req, stall_out));
        out_q.delete();
        bus_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'h0000_0010, 32'h0, 3'b010, 1'b1, 1'b0, 3'd0, 1, 1, 32'hCAFE_F00D, 1'b0, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
